// File: rtl/alu_issue_ctrl.sv
// Issue/control stage in front of a combinational RV32 ALU. Optional M-extension ops are enabled by RV_MEXT_EN.
// Latency: accept->out_valid is 2 clks for simple ops, MUL_LAT+1 / DIV_LAT+1 for M ops, 1 clk for illegal.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then one idle cycle follows.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [3:0]  alu_s,
    input  logic [31:0] alu_result,
    input  logic        alu_equal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_taken,
    output logic        out_illegal
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? ((MUL_LAT > 1) ? MUL_LAT : 1)
                                                 : ((DIV_LAT > 1) ? DIV_LAT : 1);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    localparam logic [3:0] S_SLL  = 4'b0000;
    localparam logic [3:0] S_SRL  = 4'b0001;
    localparam logic [3:0] S_ADD  = 4'b0010;
    localparam logic [3:0] S_AND  = 4'b0011;
    localparam logic [3:0] S_OR   = 4'b0100;
    localparam logic [3:0] S_XOR  = 4'b0101;
    localparam logic [3:0] S_SLTU = 4'b0110;
    localparam logic [3:0] S_MUL  = 4'b0111;
    localparam logic [3:0] S_MULH = 4'b1000;
    localparam logic [3:0] S_DIVU = 4'b1001;
    localparam logic [3:0] S_REMU = 4'b1010;
    localparam logic [3:0] S_SUB  = 4'b1011;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {K_ALU, K_BEQ, K_BNE, K_BLTU, K_BGEU, K_DIVU, K_REMU} kind_t;

    state_t             state, state_nxt;
    kind_t              kind, dec_kind;
    logic [3:0]         dec_s;
    logic               dec_ill;
    logic [CNT_W-1:0]   dec_lat, cnt;
    logic [31:0]        cap_result;
    logic               cap_taken;

    always_comb begin
        dec_s    = S_ADD;
        dec_kind = K_ALU;
        dec_ill  = 1'b0;
        dec_lat  = CNT_W'(1);
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_s = S_ADD;
                            3'b001:  dec_s = S_SLL;
                            3'b011:  dec_s = S_SLTU;
                            3'b100:  dec_s = S_XOR;
                            3'b101:  dec_s = S_SRL;
                            3'b110:  dec_s = S_OR;
                            3'b111:  dec_s = S_AND;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    // Only SUB lives here; SRA has no ALU code and is rejected.
                    7'b0100000: begin
                        if (funct3 == 3'b000) dec_s = S_SUB;
                        else                  dec_ill = 1'b1;
                    end
`ifdef RV_MEXT_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000: begin dec_s = S_MUL;  dec_lat = CNT_W'(MUL_LAT); end
                            3'b001: begin dec_s = S_MULH; dec_lat = CNT_W'(MUL_LAT); end
                            3'b101: begin dec_s = S_DIVU; dec_lat = CNT_W'(DIV_LAT); dec_kind = K_DIVU; end
                            3'b111: begin dec_s = S_REMU; dec_lat = CNT_W'(DIV_LAT); dec_kind = K_REMU; end
                            default: dec_ill = 1'b1;
                        endcase
                    end
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_IMM: begin
                case (funct3)
                    3'b000: dec_s = S_ADD;
                    3'b001: begin
                        if (funct7 == 7'b0000000) dec_s = S_SLL;
                        else                      dec_ill = 1'b1;
                    end
                    3'b011: dec_s = S_SLTU;
                    3'b100: dec_s = S_XOR;
                    3'b101: begin
                        if (funct7 == 7'b0000000) dec_s = S_SRL;
                        else                      dec_ill = 1'b1;
                    end
                    3'b110: dec_s = S_OR;
                    3'b111: dec_s = S_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_BR: begin
                case (funct3)
                    3'b000: begin dec_s = S_SUB;  dec_kind = K_BEQ;  end
                    3'b001: begin dec_s = S_SUB;  dec_kind = K_BNE;  end
                    3'b110: begin dec_s = S_SLTU; dec_kind = K_BLTU; end
                    3'b111: begin dec_s = S_SLTU; dec_kind = K_BGEU; end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Divide-by-zero results are fixed here rather than trusted from the ALU.
    always_comb begin
        cap_result = alu_result;
        cap_taken  = 1'b0;
        case (kind)
            K_DIVU: if (alu_y == 32'd0) cap_result = 32'hFFFF_FFFF;
            K_REMU: if (alu_y == 32'd0) cap_result = alu_x;
            K_BEQ:  begin cap_result = 32'd0; cap_taken = alu_equal;      end
            K_BNE:  begin cap_result = 32'd0; cap_taken = !alu_equal;     end
            K_BLTU: begin cap_result = 32'd0; cap_taken = alu_result[0];  end
            K_BGEU: begin cap_result = 32'd0; cap_taken = !alu_result[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = dec_ill ? DONE : EXEC;
            end
            EXEC: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_x       <= 32'd0;
            alu_y       <= 32'd0;
            alu_s       <= S_ADD;
            kind        <= K_ALU;
            cnt         <= '0;
            out_result  <= 32'd0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_x       <= op_a;
                        alu_y       <= op_b;
                        alu_s       <= dec_s;
                        kind        <= dec_kind;
                        cnt         <= dec_lat;
                        out_result  <= 32'd0;
                        out_taken   <= 1'b0;
                        out_illegal <= dec_ill;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        out_result <= cap_result;
                        out_taken  <= cap_taken;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and an expected-result queue.
module tb_alu_issue_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, alu_x, alu_y, alu_result, out_result;
    logic [3:0]  alu_s;
    logic        alu_equal, out_valid, out_ready, out_taken, out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_result(alu_result),
        .alu_equal(alu_equal), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_taken(out_taken), .out_illegal(out_illegal)
    );

    // External ALU; divide by zero returns a marker the controller must override.
    always_comb begin
        case (alu_s)
            4'b0000: alu_result = alu_x << alu_y[4:0];
            4'b0001: alu_result = alu_x >> alu_y[4:0];
            4'b0010: alu_result = alu_x + alu_y;
            4'b0011: alu_result = alu_x & alu_y;
            4'b0100: alu_result = alu_x | alu_y;
            4'b0101: alu_result = alu_x ^ alu_y;
            4'b0110: alu_result = {31'd0, alu_x < alu_y};
            4'b0111: alu_result = alu_x * alu_y;
            4'b1000: alu_result = {16'd0, alu_x[31:16]} * {16'd0, alu_y[31:16]};
            4'b1001: alu_result = (alu_y == 32'd0) ? 32'h0BAD_0BAD : alu_x / alu_y;
            4'b1010: alu_result = (alu_y == 32'd0) ? 32'h0BAD_0BAD : alu_x % alu_y;
            4'b1011: alu_result = alu_x - alu_y;
            default: alu_result = 32'd0;
        endcase
        alu_equal = (alu_x == alu_y);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] es, input logic [31:0] er, input logic et,
                        input logic ei, input int lat);
        exp_t e;
        e.res = er; e.tk = et; e.ill = ei; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        opcode = opc; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (!ei) begin
            chk({tag, "/alu_s"}, {28'd0, alu_s}, {28'd0, es});
            chk({tag, "/alu_x"}, alu_x, a);
            chk({tag, "/alu_y"}, alu_y, b);
        end
    endtask

    task automatic recv(input string tag, input int hold);
        exp_t e;
        int n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, n, e.lat);
        chk({tag, "/out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "/result"}, out_result, e.res);
        chk({tag, "/taken"}, {31'd0, out_taken}, {31'd0, e.tk});
        chk({tag, "/illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
        chk({tag, "/busy"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "/hold_result"}, out_result, e.res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/drop_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "/idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic illegal(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7);
        send(tag, opc, f3, f7, 32'd77, 32'd88, 4'd0, 32'd0, 1'b0, 1'b1, 1);
        recv(tag, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst/alu_x", alu_x, 32'd0);
        chk("rst/alu_y", alu_y, 32'd0);
        chk("rst/alu_s", {28'd0, alu_s}, 32'd2);
        chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst/out_result", out_result, 32'd0);
        chk("rst/out_taken", {31'd0, out_taken}, 32'd0);
        chk("rst/out_illegal", {31'd0, out_illegal}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst/in_ready", {31'd0, in_ready}, 32'd1);

        send("add", OP, 3'b000, 7'b0000000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, 2);
        recv("add", 0);
        send("sub", OP, 3'b000, 7'b0100000, 32'd3, 32'd5, 4'b1011, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
        recv("sub", 4);
        send("sll", OP, 3'b001, 7'b0000000, 32'd1, 32'd35, 4'b0000, 32'd8, 1'b0, 1'b0, 2);
        recv("sll", 0);
        send("srl", OP, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 4'b0001, 32'h0800_0000, 1'b0, 1'b0, 2);
        recv("srl", 0);
        send("sltu", OP, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 4'b0110, 32'd1, 1'b0, 1'b0, 2);
        recv("sltu", 0);
        send("xor", OP, 3'b100, 7'b0000000, 32'h0000_00F0, 32'h0000_00FF, 4'b0101, 32'h0000_000F, 1'b0, 1'b0, 2);
        recv("xor", 0);
        send("or", OP, 3'b110, 7'b0000000, 32'h0000_00F0, 32'h0000_000C, 4'b0100, 32'h0000_00FC, 1'b0, 1'b0, 2);
        recv("or", 1);
        send("and", OP, 3'b111, 7'b0000000, 32'h0000_00F0, 32'h0000_003C, 4'b0011, 32'h0000_0030, 1'b0, 1'b0, 2);
        recv("and", 0);
        send("addi", IMM, 3'b000, 7'b1111111, 32'd10, 32'hFFFF_FFFF, 4'b0010, 32'd9, 1'b0, 1'b0, 2);
        recv("addi", 0);
        send("slli", IMM, 3'b001, 7'b0000000, 32'd3, 32'd2, 4'b0000, 32'd12, 1'b0, 1'b0, 2);
        recv("slli", 0);

        send("beq", BR, 3'b000, 7'd0, 32'd4, 32'd4, 4'b1011, 32'd0, 1'b1, 1'b0, 2);
        recv("beq", 0);
        send("bne", BR, 3'b001, 7'd0, 32'd9, 32'd9, 4'b1011, 32'd0, 1'b0, 1'b0, 2);
        recv("bne", 0);
        send("bgeu", BR, 3'b111, 7'd0, 32'd1, 32'd2, 4'b0110, 32'd0, 1'b0, 1'b0, 2);
        recv("bgeu", 0);
        send("bltu", BR, 3'b110, 7'd0, 32'd1, 32'd2, 4'b0110, 32'd0, 1'b1, 1'b0, 2);
        recv("bltu", 0);

        illegal("br010", BR, 3'b010, 7'd0);
        illegal("sra", OP, 3'b101, 7'b0100000);
        illegal("srai", IMM, 3'b101, 7'b0100000);
        illegal("slt", OP, 3'b010, 7'b0000000);
        illegal("f7bad", OP, 3'b000, 7'b0000010);
        illegal("opcbad", 7'b0000011, 3'b000, 7'd0);

`ifdef RV_MEXT_EN
        send("mul", OP, 3'b000, 7'b0000001, 32'd6, 32'd7, 4'b0111, 32'd42, 1'b0, 1'b0, MUL_LAT + 1);
        recv("mul", 0);
        send("mulh", OP, 3'b001, 7'b0000001, 32'h0003_0000, 32'h0005_0000, 4'b1000, 32'd15, 1'b0, 1'b0, MUL_LAT + 1);
        recv("mulh", 0);
        send("divu", OP, 3'b101, 7'b0000001, 32'd100, 32'd7, 4'b1001, 32'd14, 1'b0, 1'b0, DIV_LAT + 1);
        recv("divu", 0);
        send("divu0", OP, 3'b101, 7'b0000001, 32'd5, 32'd0, 4'b1001, 32'hFFFF_FFFF, 1'b0, 1'b0, DIV_LAT + 1);
        recv("divu0", 0);
        send("remu0", OP, 3'b111, 7'b0000001, 32'd13, 32'd0, 4'b1010, 32'd13, 1'b0, 1'b0, DIV_LAT + 1);
        recv("remu0", 0);
        send("remu", OP, 3'b111, 7'b0000001, 32'd13, 32'd5, 4'b1010, 32'd3, 1'b0, 1'b0, DIV_LAT + 1);
        recv("remu", 0);
        illegal("m010", OP, 3'b010, 7'b0000001);
`else
        illegal("mul", OP, 3'b000, 7'b0000001);
        illegal("divu", OP, 3'b101, 7'b0000001);
`endif

        // Reset while the op is still in EXEC: nothing may come out.
        @(negedge clk);
`ifdef RV_MEXT_EN
        opcode = OP; funct3 = 3'b101; funct7 = 7'b0000001;
`else
        opcode = OP; funct3 = 3'b000; funct7 = 7'b0000000;
`endif
        op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rexec/busy", {31'd0, in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rexec/alu_x", alu_x, 32'd0);
        chk("rexec/alu_s", {28'd0, alu_s}, 32'd2);
        repeat (3) begin
            @(negedge clk);
            chk("rexec/out_valid", {31'd0, out_valid}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("rexec/in_ready", {31'd0, in_ready}, 32'd1);
        chk("rexec/no_result", {31'd0, out_valid}, 32'd0);
        send("add2", OP, 3'b000, 7'b0000000, 32'd20, 32'd22, 4'b0010, 32'd42, 1'b0, 1'b0, 2);
        recv("add2", 0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
